// File: rtl/help_img_scan.sv
`default_nettype none
// ============================================================================
// help_img_scan : 640x480@60 VGA scanner that requests help-image pixels from
//                 the ROM reader and drives latency-aligned RGB and syncs.
// Rev 1.0
// ============================================================================
module help_img_scan #(
  parameter int          WIN_X   = 180,
  parameter int          WIN_Y   = 140,
  parameter int          IMG_W   = 280,
  parameter int          IMG_H   = 200,
  parameter int          ROM_LAT = 1,
  parameter logic [11:0] KEY_CLR = 12'hF0F,
  parameter logic [11:0] BG_CLR  = 12'h000,
  parameter int          H_ACT   = 640,
  parameter int          H_FP    = 16,
  parameter int          H_SYNC  = 96,
  parameter int          H_BP    = 48,
  parameter int          V_ACT   = 480,
  parameter int          V_FP    = 10,
  parameter int          V_SYNC  = 2,
  parameter int          V_BP    = 33
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        en,
  output logic [9:0]  img_x,
  output logic [8:0]  img_y,
  input  logic [11:0] img_clr,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs,
  output logic        showing
);

  localparam logic [9:0] c_h_last = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_v_last = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_h_act  = 10'(H_ACT);
  localparam logic [9:0] c_v_act  = 10'(V_ACT);
  localparam logic [9:0] c_hs_beg = 10'(H_ACT + H_FP);
  localparam logic [9:0] c_hs_end = 10'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_vs_beg = 10'(V_ACT + V_FP);
  localparam logic [9:0] c_vs_end = 10'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [9:0] c_wx_beg = 10'(WIN_X);
  localparam logic [9:0] c_wx_end = 10'(WIN_X + IMG_W - 1);
  localparam logic [9:0] c_wy_beg = 10'(WIN_Y);
  localparam logic [9:0] c_wy_end = 10'(WIN_Y + IMG_H - 1);
  // Flag stages ahead of the output register; lines flags up with img_clr.
  localparam int c_dly = ROM_LAT + 1;
  localparam int c_hs  = 4;
  localparam int c_vs  = 3;
  localparam int c_act = 2;
  localparam int c_win = 1;
  localparam int c_shw = 0;

  typedef enum logic {
    ST_HIDDEN = 1'b0,
    ST_SHOWN  = 1'b1
  } state_e;

  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0]  img_x_q, img_x_d;
  logic [8:0]  img_y_q, img_y_d;
  logic [11:0] clr_q, clr_d;
  logic        hs_q, vs_q;
  state_e      state_q, state_d;
  logic [4:0]  flg_q [c_dly];
  logic [4:0]  w_flg, w_tail;
  logic        w_h_end, w_v_end, w_active, w_in_win, w_hs_raw, w_vs_raw;

  assign w_h_end  = (h_cnt_q == c_h_last);
  assign w_v_end  = (v_cnt_q == c_v_last);
  assign w_active = (h_cnt_q < c_h_act) && (v_cnt_q < c_v_act);
  assign w_hs_raw = !((h_cnt_q >= c_hs_beg) && (h_cnt_q <= c_hs_end));
  assign w_vs_raw = !((v_cnt_q >= c_vs_beg) && (v_cnt_q <= c_vs_end));
  assign w_in_win = (h_cnt_q >= c_wx_beg) && (h_cnt_q <= c_wx_end) &&
                    (v_cnt_q >= c_wy_beg) && (v_cnt_q <= c_wy_end);
  assign w_flg    = {w_hs_raw, w_vs_raw, w_active, w_in_win, (state_q == ST_SHOWN)};
  assign w_tail   = flg_q[c_dly-1];

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (w_h_end) begin
      h_cnt_d = '0;
      v_cnt_d = w_v_end ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    img_x_d = '0;
    img_y_d = '0;
    if (w_in_win) begin
      img_x_d = h_cnt_q - c_wx_beg;
      img_y_d = 9'(v_cnt_q - c_wy_beg);
    end
  end

  // en only takes effect at the last pixel of a frame so no frame is partial.
  always_comb begin
    state_d = state_q;
    if (w_h_end && w_v_end) begin
      state_d = en ? ST_SHOWN : ST_HIDDEN;
    end
  end

  always_comb begin
    clr_d = 12'h000;
    if (w_tail[c_act]) begin
      clr_d = BG_CLR;
      if (w_tail[c_shw] && w_tail[c_win] && (img_clr != KEY_CLR)) begin
        clr_d = img_clr;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      img_x_q <= '0;
      img_y_q <= '0;
      state_q <= ST_HIDDEN;
      clr_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      for (int i = 0; i < c_dly; i++) begin
        flg_q[i] <= 5'b11000;
      end
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      img_x_q  <= img_x_d;
      img_y_q  <= img_y_d;
      state_q  <= state_d;
      clr_q    <= clr_d;
      hs_q     <= w_tail[c_hs];
      vs_q     <= w_tail[c_vs];
      flg_q[0] <= w_flg;
      for (int i = 1; i < c_dly; i++) begin
        flg_q[i] <= flg_q[i-1];
      end
    end
  end

  assign img_x   = img_x_q;
  assign img_y   = img_y_q;
  assign r       = clr_q[11:8];
  assign g       = clr_q[7:4];
  assign b       = clr_q[3:0];
  assign hs      = hs_q;
  assign vs      = vs_q;
  assign showing = (state_q == ST_SHOWN);

endmodule
`default_nettype wire

// File: tb/tb_help_img_scan.sv
`default_nettype none
// ============================================================================
// tb_help_img_scan : self-checking bench for help_img_scan (full VGA timing
//                    instance plus two reduced-geometry instances, ROM_LAT 1/3).
// Rev 1.0
// ============================================================================
module tb_help_img_scan;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    int          h;
    int          v;
    bit          show;
  } exp_t;

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
  } spot_t;

  logic  clk = 1'b0;
  logic  clrn;
  logic  en;
  int    checks = 0;
  int    failures = 0;
  int    spot_hits [3] = '{0, 0, 0};
  spot_t spots [10];

  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] rom_fn(input logic [9:0] x, input logic [8:0] y,
                                         input int kx, input int ky);
    if (int'(x) == kx && int'(y) == ky) return 12'hF0F;
    return {x[3:0], y[3:0], 4'h5};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam bit          BIG = (k == 0);
    localparam int          LAT = (k == 2) ? 3 : 1;
    localparam int          HA  = BIG ? 640 : 16;
    localparam int          HF  = BIG ? 16  : 2;
    localparam int          HS  = BIG ? 96  : 3;
    localparam int          HB  = BIG ? 48  : 3;
    localparam int          VA  = BIG ? 480 : 12;
    localparam int          VF  = BIG ? 10  : 1;
    localparam int          VS  = 2;
    localparam int          VB  = BIG ? 33  : 1;
    localparam int          WX  = BIG ? 180 : 4;
    localparam int          WY  = BIG ? 140 : 3;
    localparam int          IW  = BIG ? 280 : 8;
    localparam int          IH  = BIG ? 200 : 6;
    localparam int          KX  = BIG ? 10  : 2;
    localparam int          KY  = BIG ? 10  : 2;
    localparam logic [11:0] BG  = BIG ? 12'h000 : 12'h123;
    localparam int          HT  = HA + HF + HS + HB;
    localparam int          VT  = VA + VF + VS + VB;

    logic [9:0]  img_x;
    logic [8:0]  img_y;
    logic [11:0] img_clr;
    logic [3:0]  r, g, b;
    logic        hs, vs, showing;
    logic [11:0] rom_q [LAT];
    int          mh, mv;
    bit          mshow;
    exp_t        q[$];

    help_img_scan #(
      .WIN_X(WX), .WIN_Y(WY), .IMG_W(IW), .IMG_H(IH), .ROM_LAT(LAT),
      .KEY_CLR(12'hF0F), .BG_CLR(BG),
      .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut (
      .clk(clk), .clrn(clrn), .en(en),
      .img_x(img_x), .img_y(img_y), .img_clr(img_clr),
      .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .showing(showing)
    );

    // ROM reader model: data for an address is valid LAT cycles later.
    always @(posedge clk) begin
      rom_q[0] <= rom_fn(img_x, img_y, KX, KY);
      for (int i = 1; i < LAT; i++) rom_q[i] <= rom_q[i-1];
    end
    assign img_clr = rom_q[LAT-1];

    // Scoreboard: expected output for each sampled counter value is queued
    // and compared when it leaves the DUT LAT+2 cycles later.
    initial begin : p_check
      exp_t        e;
      bit          act, inw;
      int          ax, ay;
      logic [11:0] pix;
      mh = 0; mv = 0; mshow = 1'b0;
      forever begin
        @(posedge clk); #1;
        if (!clrn) begin
          chk($sformatf("rst_out%0d", k), {r, g, b, hs, vs, showing}, {12'h000, 3'b110});
          chk($sformatf("rst_addr%0d", k), {img_x, img_y}, 19'h0);
          mh = 0; mv = 0; mshow = 1'b0;
          q.delete();
          e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, h: -1, v: -1, show: 1'b0};
          repeat (LAT + 1) q.push_back(e);
        end else begin
          act    = (mh < HA) && (mv < VA);
          inw    = (mh >= WX) && (mh < WX + IW) && (mv >= WY) && (mv < WY + IH);
          ax     = inw ? mh - WX : 0;
          ay     = inw ? mv - WY : 0;
          pix    = rom_fn(10'(ax), 9'(ay), KX, KY);
          e.h    = mh;
          e.v    = mv;
          e.show = mshow;
          e.hs   = !((mh >= HA + HF) && (mh < HA + HF + HS));
          e.vs   = !((mv >= VA + VF) && (mv < VA + VF + VS));
          e.rgb  = !act ? 12'h000 : ((mshow && inw && pix != 12'hF0F) ? pix : BG);
          q.push_back(e);
          chk($sformatf("addr%0d", k), {img_x, img_y}, {10'(ax), 9'(ay)});
          if (mh == HT - 1) begin
            mh = 0;
            if (mv == VT - 1) begin
              mv = 0;
              mshow = en;
            end else begin
              mv++;
            end
          end else begin
            mh++;
          end
          chk($sformatf("showing%0d", k), showing, mshow);
          if (q.size() == LAT + 2) begin
            e = q.pop_front();
            chk($sformatf("out%0d h%0d v%0d", k, e.h, e.v), {r, g, b, hs, vs},
                {e.rgb, e.hs, e.vs});
            for (int i = 0; i < 10; i++) begin
              if (e.show && e.h == spots[i].h && e.v == spots[i].v) begin
                chk($sformatf("spot%0d_%0d", k, i), {r, g, b}, spots[i].rgb);
                spot_hits[k]++;
              end
            end
          end
        end
      end
    end
  end

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    while (!(g_dut[1].mh == h && g_dut[1].mv == v) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pos", (n < 1000), 1);
  endtask

  task automatic chk_async_rst();
    chk("async_out1", {g_dut[1].r, g_dut[1].g, g_dut[1].b, g_dut[1].hs, g_dut[1].vs,
                       g_dut[1].showing}, {12'h000, 3'b110});
    chk("async_out2", {g_dut[2].r, g_dut[2].g, g_dut[2].b, g_dut[2].hs, g_dut[2].vs,
                       g_dut[2].showing}, {12'h000, 3'b110});
    chk("async_addr1", {g_dut[1].img_x, g_dut[1].img_y}, 19'h0);
    chk("async_addr2", {g_dut[2].img_x, g_dut[2].img_y}, 19'h0);
  endtask

  initial begin
    // Hand-derived pixels of the reduced geometry (window x 4..11, y 3..8, BG 123).
    spots[0] = '{h: 4,  v: 3, rgb: 12'h005};
    spots[1] = '{h: 11, v: 8, rgb: 12'h755};
    spots[2] = '{h: 12, v: 9, rgb: 12'h123};
    spots[3] = '{h: 6,  v: 5, rgb: 12'h123};
    spots[4] = '{h: 5,  v: 5, rgb: 12'h125};
    spots[5] = '{h: 7,  v: 5, rgb: 12'h325};
    spots[6] = '{h: 3,  v: 3, rgb: 12'h123};
    spots[7] = '{h: 17, v: 3, rgb: 12'h000};
    spots[8] = '{h: 4,  v: 8, rgb: 12'h055};
    spots[9] = '{h: 11, v: 3, rgb: 12'h705};

    clrn = 1'b0;
    en   = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (2 * 384 + 50) @(negedge clk);

    // en raised mid-frame: nothing changes until the frame-end sample.
    wait_pos(0, 5);
    en = 1'b1;
    @(negedge clk);
    chk("hold_mid", g_dut[1].showing, 1'b0);
    wait_pos(23, 15);
    chk("hold_end", g_dut[1].showing, 1'b0);
    @(negedge clk);
    chk("shown1", g_dut[1].showing, 1'b1);
    chk("shown2", g_dut[2].showing, 1'b1);
    repeat (2 * 384) @(negedge clk);

    // Asynchronous reset in the middle of the image window.
    wait_pos(10, 6);
    clrn = 1'b0;
    #1;
    chk_async_rst();
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    chk("post_rst_hidden", g_dut[1].showing, 1'b0);
    repeat (2 * 384 + 20) @(negedge clk);

    // en dropped mid-frame: image stays until the frame end.
    wait_pos(0, 7);
    en = 1'b0;
    wait_pos(23, 15);
    chk("still_shown", g_dut[1].showing, 1'b1);
    @(negedge clk);
    chk("hidden_again", g_dut[1].showing, 1'b0);
    repeat (384 + 20) @(negedge clk);

    chk("spot_cov1", (spot_hits[1] >= 10), 1);
    chk("spot_cov2", (spot_hits[2] >= 10), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
